key_event_unit: RTL and testbench

KEY_EVENT_UNIT -- requirements
Module: key_event_unit

---
 rtl/key_event_unit_pkg.sv | 6 +
 rtl/key_event_unit_debounce_ch.sv | 63 ++++++
 rtl/key_event_unit.sv | 59 +++++
 tb/tb_key_event_unit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/key_event_unit_pkg.sv
// key_event_unit_pkg: constants shared by the key event unit and its
// per-key debounce channel.
package key_event_unit_pkg;
  localparam int   NUM_KEYS_DEF = 4;     // default number of key channels
  localparam logic KEY_RELEASED = 1'b1;  // keys are active-low; 1 = released
endpackage

// File: rtl/key_event_unit_debounce_ch.sv
// key_debounce_ch: one key channel. The key is synchronized by two flops,
// then debounced by a counter that must observe DB_CYCLES consecutive
// cycles of disagreement before the debounced level follows the key.
// Ports:
//   clk_i, rst_i (async, active-high)
//   key_i     raw key pin (active-low)
//   level_o   debounced level (active-low)
//   press_o   one-cycle strobe when the debounced level falls
//   release_o one-cycle strobe when the debounced level rises
module key_debounce_ch
  import key_event_unit_pkg::*;
#(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1_q, sync2_q, level_q, level_d;
  logic          press_q, release_q, flip;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles where the synchronized key disagrees with the
  // debounced level; any agreement restarts the count. The terminal count
  // flips the level and wraps to 0, so the counter never passes DB_CYCLES-1.
  always_comb begin
    flip  = 1'b0;
    cnt_d = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) flip  = 1'b1;
      else                             cnt_d = cnt_q + 1'b1;
    end
    level_d = flip ? sync2_q : level_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= KEY_RELEASED;
      sync2_q   <= KEY_RELEASED;
      level_q   <= KEY_RELEASED;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= key_i;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      // On a flip sync2 is the new level: 0 means a press, 1 a release.
      press_q   <= flip & ~sync2_q;
      release_q <= flip &  sync2_q;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
endmodule

// File: rtl/key_event_unit.sv
// key_event_unit: NUM_KEYS debounced key channels plus sticky press-pending
// flags and a registered, maskable level interrupt.
// Ports:
//   HCLK, HRESET (async, active-high)
//   FPGA_Key      raw key pins, active-low
//   key_level     debounced levels, active-low
//   press_pulse   per-key one-cycle press strobes
//   release_pulse per-key one-cycle release strobes
//   pending       sticky press flags, write-1-to-clear via pending_clr
//   pending_clr   clear strobes for pending
//   irq_en        per-key interrupt enables
//   key_irq       registered |(pending & irq_en)
module key_event_unit
  import key_event_unit_pkg::*;
#(
  parameter int NUM_KEYS  = NUM_KEYS_DEF,
  parameter int DB_CYCLES = 1000000
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic [NUM_KEYS-1:0] FPGA_Key,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] pending,
  input  logic [NUM_KEYS-1:0] pending_clr,
  input  logic [NUM_KEYS-1:0] irq_en,
  output logic                key_irq
);
  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic                key_irq_q;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_ch (
      .clk_i    (HCLK),
      .rst_i    (HRESET),
      .key_i    (FPGA_Key[i]),
      .level_o  (key_level[i]),
      .press_o  (press_pulse[i]),
      .release_o(release_pulse[i])
    );
  end

  // Set wins over a simultaneous clear.
  assign pending_d = (pending_q & ~pending_clr) | press_pulse;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pending_q <= '0;
      key_irq_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      key_irq_q <= |(pending_q & irq_en);
    end
  end

  assign pending = pending_q;
  assign key_irq = key_irq_q;
endmodule

// File: tb/tb_key_event_unit.sv
module tb_key_event_unit;
  localparam int NK = 4;
  localparam int DB = 4;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [NK-1:0] FPGA_Key, pending_clr, irq_en;
  logic [NK-1:0] key_level, press_pulse, release_pulse, pending;
  logic          key_irq;

  int vectors = 0, miscompares = 0;
  int p0_cnt = 0, p3_cnt = 0;
  bit started = 0;

  key_event_unit #(.NUM_KEYS(NK), .DB_CYCLES(DB)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .FPGA_Key(FPGA_Key), .key_level(key_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .pending(pending),
    .pending_clr(pending_clr), .irq_en(irq_en), .key_irq(key_irq)
  );

  always #10 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the debounced level of a key flips once the last DB
  // synchronized samples (pin samples 2..DB+1 edges old) all disagree with it.
  logic [NK-1:0] h [0:DB];  // h[0] = pin sampled at the previous edge
  logic [NK-1:0] m_lvl, m_press, m_rel, m_pend, m_flip, m_npend;
  logic          m_irq;
  bit            all_diff;

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int j = 0; j <= DB; j++) h[j] = '1;
      m_lvl = '1; m_press = '0; m_rel = '0; m_pend = '0; m_irq = 1'b0;
    end else begin
      m_npend = (m_pend & ~pending_clr) | m_press;
      m_irq   = |(m_pend & irq_en);
      for (int k = 0; k < NK; k++) begin
        all_diff = 1;
        for (int j = 1; j <= DB; j++) if (h[j][k] == m_lvl[k]) all_diff = 0;
        m_flip[k] = all_diff;
      end
      m_press = m_flip & m_lvl;
      m_rel   = m_flip & ~m_lvl;
      m_lvl   = m_lvl ^ m_flip;
      m_pend  = m_npend;
      for (int j = DB; j >= 1; j--) h[j] = h[j-1];
      h[0] = FPGA_Key;
    end
  end

  always @(negedge HCLK) begin
    if (started) begin
      chk("key_level", key_level, m_lvl);
      chk("press_pulse", press_pulse, m_press);
      chk("release_pulse", release_pulse, m_rel);
      chk("pending", pending, m_pend);
      chk("key_irq", key_irq, m_irq);
      if (press_pulse[0]) p0_cnt++;
      if (press_pulse[3]) p3_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge HCLK);
    #2;
  endtask

  int base;

  initial begin
    HRESET = 1'b1; FPGA_Key = '1; pending_clr = '0; irq_en = '0;
    @(posedge HCLK); #1 started = 1;
    cyc(2);
    chk("rst_level", key_level, 4'hF);
    chk("rst_pending", pending, 4'h0);
    HRESET = 1'b0;

    // All keys pressed for 100 ns, then released.
    FPGA_Key = 4'h0; cyc(5);
    FPGA_Key = 4'hF; cyc(12);
    chk("all_pending", pending, 4'hF);
    pending_clr = 4'hF; cyc(1); pending_clr = 4'h0; cyc(2);

    // Two-cycle glitch on key0 is filtered.
    FPGA_Key = 4'hE; cyc(2); FPGA_Key = 4'hF; cyc(10);
    chk("glitch_level", key_level, 4'hF);
    chk("glitch_pending", pending, 4'h0);

    // Bounce then hold on key0: one press.
    base = p0_cnt;
    FPGA_Key = 4'hE; cyc(1); FPGA_Key = 4'hF; cyc(1); FPGA_Key = 4'hE; cyc(12);
    chk("bounce_presses", p0_cnt - base, 1);
    FPGA_Key = 4'hF; cyc(10);
    pending_clr = 4'hF; cyc(1); pending_clr = 4'h0; cyc(2);

    // Interrupt masking.
    irq_en = 4'h1;
    FPGA_Key = 4'hD; cyc(10);
    chk("irq_masked", key_irq, 1'b0);
    FPGA_Key = 4'hC; cyc(10);
    chk("irq_set", key_irq, 1'b1);
    pending_clr = 4'h1; cyc(1); pending_clr = 4'h0; cyc(2);
    chk("irq_clr", key_irq, 1'b0);
    FPGA_Key = 4'hF; cyc(10);
    pending_clr = 4'hF; cyc(1); pending_clr = 4'h0; cyc(2);

    // Clear coincident with press on key2: set wins.
    FPGA_Key = 4'hB; cyc(6);
    pending_clr = 4'h4; cyc(1); pending_clr = 4'h0; cyc(1);
    chk("set_wins", pending[2], 1'b1);
    FPGA_Key = 4'hF; cyc(10);
    pending_clr = 4'hF; cyc(1); pending_clr = 4'h0; cyc(2);

    // Reset during key3 debounce; held key reported once afterwards.
    base = p3_cnt;
    FPGA_Key = 4'h7; cyc(4);
    HRESET = 1'b1; cyc(1);
    chk("midrst_level", key_level, 4'hF);
    HRESET = 1'b0; cyc(12);
    chk("midrst_presses", p3_cnt - base, 1);
    FPGA_Key = 4'hF; cyc(10);

    // Randomized phase.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NK; k++)
        if ($urandom_range(7) == 0) FPGA_Key[k] = ~FPGA_Key[k];
      for (int k = 0; k < NK; k++) pending_clr[k] = ($urandom_range(5) == 0);
      if ($urandom_range(31) == 0) irq_en = NK'($urandom);
      HRESET = ($urandom_range(399) == 0);
      cyc(1);
    end
    HRESET = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
